// File: rtl/axis_width_pkg.sv
// rtl/axis_width_pkg.sv - shared helpers for the AXI-Stream width downsizer
package axis_width_pkg;

  // Bit width needed to count 0..n-1, never less than one bit.
  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Maps an emission position to the slice index it reads.
  function automatic int slice_pos(input int p, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - p) : p;
  endfunction

endpackage

// File: rtl/axis_keep_beat_count.sv
// rtl/axis_keep_beat_count.sv - number of narrow beats needed for one wide word
module axis_keep_beat_count
  import axis_width_pkg::*;
#(
  parameter int OUT_W      = 512,
  parameter int RATIO      = 2,
  parameter int MSB_FIRST  = 1,
  parameter int DROP_EMPTY = 1,
  localparam int KW        = OUT_W / 8,
  localparam int CW        = clog2_safe(RATIO + 1)
) (
  input  logic [RATIO*KW-1:0] keep,
  input  logic                last,
  output logic [CW-1:0]       nbeats
);

  // Last words stop after the highest emission position carrying any byte;
  // an all-empty last word still yields one beat so TLAST reaches the sink.
  always_comb begin
    nbeats = CW'(1);
    if (!last || (DROP_EMPTY == 0)) begin
      nbeats = CW'(RATIO);
    end else begin
      for (int p = 0; p < RATIO; p++) begin
        if (|keep[slice_pos(p, RATIO, MSB_FIRST != 0) * KW +: KW]) nbeats = CW'(p + 1);
      end
    end
  end

endmodule

// File: rtl/axis_width_downsizer.sv
// rtl/axis_width_downsizer.sv - splits RATIO*OUT_W-bit stream words into OUT_W-bit beats
module axis_width_downsizer
  import axis_width_pkg::*;
#(
  parameter int OUT_W      = 512,
  parameter int RATIO      = 2,
  parameter int MSB_FIRST  = 1,
  parameter int DROP_EMPTY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     in_ready,
  input  logic [RATIO*OUT_W-1:0]   in_data,
  input  logic [RATIO*OUT_W/8-1:0] in_keep,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [OUT_W/8-1:0]       out_keep,
  output logic                     out_valid,
  output logic                     out_last
);

  localparam int KW = OUT_W / 8;
  localparam int XW = clog2_safe(RATIO);
  localparam int CW = clog2_safe(RATIO + 1);

  logic [RATIO*OUT_W-1:0] buf_data_q, buf_data_d;
  logic [RATIO*KW-1:0]    buf_keep_q, buf_keep_d;
  logic                   buf_last_q, buf_last_d;
  logic                   buf_valid_q, buf_valid_d;
  logic [XW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          nbeats_q, nbeats_d;
  logic [CW-1:0]          in_nbeats;
  logic                   last_beat;
  logic                   accept;
  int                     sel;

  axis_keep_beat_count #(
    .OUT_W     (OUT_W),
    .RATIO     (RATIO),
    .MSB_FIRST (MSB_FIRST),
    .DROP_EMPTY(DROP_EMPTY)
  ) u_beat_count (
    .keep  (in_keep),
    .last  (in_last),
    .nbeats(in_nbeats)
  );

  assign last_beat = (CW'(idx_q) == (nbeats_q - CW'(1)));
  // Ready when empty or when the final beat leaves this cycle, so words chain without bubbles.
  assign in_ready  = rst_n & (~buf_valid_q | (out_ready & last_beat));
  assign accept    = in_valid & in_ready;

  // Load a new word on accept, otherwise step through the buffered word's beats.
  always_comb begin
    buf_data_d  = buf_data_q;
    buf_keep_d  = buf_keep_q;
    buf_last_d  = buf_last_q;
    buf_valid_d = buf_valid_q;
    idx_d       = idx_q;
    nbeats_d    = nbeats_q;
    if (accept) begin
      buf_data_d  = in_data;
      buf_keep_d  = in_keep;
      buf_last_d  = in_last;
      buf_valid_d = 1'b1;
      idx_d       = '0;
      nbeats_d    = in_nbeats;
    end else if (buf_valid_q && out_ready) begin
      if (last_beat) begin
        buf_valid_d = 1'b0;
        buf_last_d  = 1'b0;
      end else begin
        idx_d = idx_q + XW'(1);
      end
    end
  end

  // State registers; reset drops any buffered word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_data_q  <= '0;
      buf_keep_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      idx_q       <= '0;
      nbeats_q    <= '0;
    end else begin
      buf_data_q  <= buf_data_d;
      buf_keep_q  <= buf_keep_d;
      buf_last_q  <= buf_last_d;
      buf_valid_q <= buf_valid_d;
      idx_q       <= idx_d;
      nbeats_q    <= nbeats_d;
    end
  end

  // Present the slice at the current emission position; zero when empty.
  always_comb begin
    sel       = slice_pos(int'(idx_q), RATIO, MSB_FIRST != 0);
    out_valid = buf_valid_q;
    out_data  = '0;
    out_keep  = '0;
    if (buf_valid_q) begin
      out_data = buf_data_q[sel*OUT_W +: OUT_W];
      out_keep = buf_keep_q[sel*KW +: KW];
    end
    out_last = buf_last_q & last_beat;
  end

endmodule

// File: tb/tb_axis_width_downsizer.sv
// tb/tb_axis_width_downsizer.sv - directed vector bench for the width downsizer
module tb_axis_width_downsizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [63:0] in_data;
  logic [7:0]  in_keep;

  logic        a_ir, a_ov, a_ol, b_ir, b_ov, b_ol, c_ir, c_ov, c_ol;
  logic [15:0] a_od, b_od, c_od;
  logic [1:0]  a_ok, b_ok, c_ok;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // a: RATIO 2, MSB first, drop empty
  axis_width_downsizer #(.OUT_W(16), .RATIO(2), .MSB_FIRST(1), .DROP_EMPTY(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_ready(a_ir), .in_data(in_data[31:0]), .in_keep(in_keep[3:0]),
    .in_valid(in_valid), .in_last(in_last), .out_ready(out_ready), .out_data(a_od),
    .out_keep(a_ok), .out_valid(a_ov), .out_last(a_ol));

  // b: RATIO 2, MSB first, keep empty slices
  axis_width_downsizer #(.OUT_W(16), .RATIO(2), .MSB_FIRST(1), .DROP_EMPTY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_ready(b_ir), .in_data(in_data[31:0]), .in_keep(in_keep[3:0]),
    .in_valid(in_valid), .in_last(in_last), .out_ready(out_ready), .out_data(b_od),
    .out_keep(b_ok), .out_valid(b_ov), .out_last(b_ol));

  // c: RATIO 4, slice 0 first, drop empty
  axis_width_downsizer #(.OUT_W(16), .RATIO(4), .MSB_FIRST(0), .DROP_EMPTY(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_ready(c_ir), .in_data(in_data), .in_keep(in_keep),
    .in_valid(in_valid), .in_last(in_last), .out_ready(out_ready), .out_data(c_od),
    .out_keep(c_ok), .out_valid(c_ov), .out_last(c_ol));

  typedef struct {
    bit          rst;
    int          sel;
    bit          iv;
    logic [63:0] id;
    logic [7:0]  ik;
    bit          il;
    bit          ordy;
    bit          co;
    bit          e_ir;
    bit          e_ov;
    logic [15:0] e_od;
    logic [1:0]  e_ok;
    bit          e_ol;
  } vec_t;

  vec_t vec[$];

  function automatic void r(bit rst, int sel, bit iv, logic [63:0] id, logic [7:0] ik, bit il,
                            bit ordy, bit co, bit e_ir, bit e_ov, logic [15:0] e_od,
                            logic [1:0] e_ok, bit e_ol);
    vec_t v;
    v.rst = rst; v.sel = sel; v.iv = iv; v.id = id; v.ik = ik; v.il = il; v.ordy = ordy;
    v.co = co; v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_ok = e_ok; v.e_ol = e_ol;
    vec.push_back(v);
  endfunction

  task automatic chk(input string name, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  logic        s_ir, s_ov, s_ol;
  logic [15:0] s_od;
  logic [1:0]  s_ok;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data = '0; in_keep = '0;

    // reset state
    r(0,0, 0,64'h0,8'h0,0, 1, 1, 0,0,16'h0,2'h0,0);
    // two full words back to back, no backpressure
    r(1,0, 1,64'hAAAA_BBBB,8'h0F,0, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,0, 1,64'hAAAA_BBBB,8'h0F,1, 1, 1, 0,1,16'hAAAA,2'h3,0);
    r(1,0, 1,64'hAAAA_BBBB,8'h0F,1, 1, 1, 1,1,16'hBBBB,2'h3,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 0,1,16'hAAAA,2'h3,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,1,16'hBBBB,2'h3,1);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);
    // last word with empty lower slice is trimmed to one beat
    r(1,0, 1,64'h1234_5678,8'h0C,1, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,1,16'h1234,2'h3,1);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);
    // all-zero keep on last word still carries TLAST
    r(1,0, 1,64'hCCCC_DDDD,8'h00,1, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,1,16'hCCCC,2'h0,1);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);
    // backpressure across three words
    r(1,0, 1,64'h1111_2222,8'h0F,0, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,0, 1,64'h3333_4444,8'h0F,0, 1, 1, 0,1,16'h1111,2'h3,0);
    r(1,0, 1,64'h3333_4444,8'h0F,0, 0, 1, 0,1,16'h2222,2'h3,0);
    r(1,0, 1,64'h3333_4444,8'h0F,0, 0, 1, 0,1,16'h2222,2'h3,0);
    r(1,0, 1,64'h3333_4444,8'h0F,0, 1, 1, 1,1,16'h2222,2'h3,0);
    r(1,0, 1,64'h5555_6666,8'h0F,1, 0, 1, 0,1,16'h3333,2'h3,0);
    r(1,0, 1,64'h5555_6666,8'h0F,1, 1, 1, 0,1,16'h3333,2'h3,0);
    r(1,0, 1,64'h5555_6666,8'h0F,1, 1, 1, 1,1,16'h4444,2'h3,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h5555,2'h3,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,1,16'h6666,2'h3,1);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);
    // reset pulse after first beat discards the second
    r(1,0, 1,64'h7777_8888,8'h0F,1, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h7777,2'h3,0);
    r(0,0, 0,64'h0,8'h0,0, 0, 1, 0,1,16'h8888,2'h3,1);
    r(1,0, 1,64'h9999_AAAA,8'h0F,1, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h9999,2'h3,0);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,1,16'hAAAA,2'h3,1);
    r(1,0, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);
    // no trimming: empty lower slice still emitted with TLAST
    r(0,1, 0,64'h0,8'h0,0, 0, 0, 0,0,16'h0,2'h0,0);
    r(1,1, 1,64'h1234_5678,8'h0C,1, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,1, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h1234,2'h3,0);
    r(1,1, 0,64'h0,8'h0,0, 1, 1, 1,1,16'h5678,2'h0,1);
    r(1,1, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);
    // RATIO 4, slice 0 first: two-beat last word then a full word
    r(0,2, 0,64'h0,8'h0,0, 0, 0, 0,0,16'h0,2'h0,0);
    r(1,2, 1,64'h4444_3333_2222_1111,8'h07,1, 1, 1, 1,0,16'h0,2'h0,0);
    r(1,2, 1,64'h8888_7777_6666_5555,8'hFF,0, 1, 1, 0,1,16'h1111,2'h3,0);
    r(1,2, 1,64'h8888_7777_6666_5555,8'hFF,0, 1, 1, 1,1,16'h2222,2'h1,1);
    r(1,2, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h5555,2'h3,0);
    r(1,2, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h6666,2'h3,0);
    r(1,2, 0,64'h0,8'h0,0, 1, 1, 0,1,16'h7777,2'h3,0);
    r(1,2, 0,64'h0,8'h0,0, 1, 1, 1,1,16'h8888,2'h3,0);
    r(1,2, 0,64'h0,8'h0,0, 1, 1, 1,0,16'h0,2'h0,0);

    repeat (2) @(posedge clk);

    foreach (vec[i]) begin
      @(negedge clk);
      rst_n     = vec[i].rst;
      in_valid  = vec[i].iv;
      in_data   = vec[i].id;
      in_keep   = vec[i].ik;
      in_last   = vec[i].il;
      out_ready = vec[i].ordy;
      #1;
      case (vec[i].sel)
        0:       begin s_ir = a_ir; s_ov = a_ov; s_od = a_od; s_ok = a_ok; s_ol = a_ol; end
        1:       begin s_ir = b_ir; s_ov = b_ov; s_od = b_od; s_ok = b_ok; s_ol = b_ol; end
        default: begin s_ir = c_ir; s_ov = c_ov; s_od = c_od; s_ok = c_ok; s_ol = c_ol; end
      endcase
      chk("in_ready", i, 16'(s_ir), 16'(vec[i].e_ir));
      if (vec[i].co) begin
        chk("out_valid", i, 16'(s_ov), 16'(vec[i].e_ov));
        chk("out_data", i, s_od, vec[i].e_od);
        chk("out_keep", i, 16'(s_ok), 16'(vec[i].e_ok));
        chk("out_last", i, 16'(s_ol), 16'(vec[i].e_ol));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_width_downsizer.md
Name: axis_width_downsizer

Overview:
- Parametrised AXI-Stream width downsizer: splits each RATIO*OUT_W-bit input word into up to RATIO OUT_W-bit output beats.
- Successor to the fixed 1024-to-512 converter, with these additions:
  - full-throughput handshake, with no lost or duplicated words under backpressure;
  - trimming of empty trailing sub-beats on the last word;
  - selectable slice order.
- Sits between the wide join/partition datapath and the narrower network/memory stream interfaces.

Parameters:
OUT_W, 512, output data width in bits; multiple of 8.
RATIO, 2, input/output width ratio; at least 2, at most 16.
MSB_FIRST, 1, 1 = emit the most significant slice first; 0 = emit slice 0 first.
DROP_EMPTY, 1, 1 = on an in_last word, skip trailing slices whose keep is all zero.

Ports:
clk  input  1  clock
rst_n  input  1  reset
in_ready  output  1  input handshake ready
in_data  input  RATIO*OUT_W  wide input data
in_keep  input  RATIO*OUT_W/8  byte enables, bit i qualifies byte i
in_valid  input  1  input valid
in_last  input  1  last word of packet
out_ready  input  1  downstream ready
out_data  output  OUT_W  narrow output data
out_keep  output  OUT_W/8  narrow byte enables
out_valid  output  1  output valid
out_last  output  1  last beat of packet

Behaviour:
- Reset: rst_n is synchronous and active-low; clock is clk.
  - While rst_n is low, in_ready is 0.
  - After reset: buffer empty, out_valid=0, out_last=0, out_data=0, out_keep=0.
  - A reset asserted mid-word discards the buffered word with no further output beats.
- Storage: one buffer register holding data, keep and last, plus buf_valid.
  - Counter idx, clog2(RATIO) bits, gives the emission position.
  - Counter nbeats gives the number of beats to emit for the buffered word.
- Slice mapping:
  - Slice k is data[k*OUT_W +: OUT_W] with keep[k*OUT_W/8 +: OUT_W/8].
  - Emission position p selects slice RATIO-1-p when MSB_FIRST=1, else slice p.
- Output signals:
  - out_valid = buf_valid.
  - out_data and out_keep = the slice at position idx, or 0 when buf_valid=0.
  - out_last = buf_last and (idx == nbeats-1).
- Input accept and load:
  - Input is accepted when in_valid and in_ready.
  - On accept: load the buffer, set idx=0, set buf_valid=1, compute nbeats.
  - nbeats = RATIO if in_last=0 or DROP_EMPTY=0.
  - Otherwise nbeats = 1 + highest emission position whose slice keep is nonzero.
  - If keep is entirely zero on a last word, nbeats=1: one beat with keep 0 and out_last=1, so TLAST is never lost.
- Output advance: when out_valid and out_ready:
  - if idx < nbeats-1, idx increments;
  - otherwise the word is complete.
- in_ready = rst_n and (not buf_valid, or (out_ready and idx == nbeats-1)).
  - Completing a word and loading the next happen in the same cycle, so there are no bubbles.
  - Sustained rate is 1 output beat per cycle, with an input word every nbeats cycles.
- Latency: a word accepted on cycle t has its first beat valid on cycle t+1.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_keep and out_last are held stable.
- No combinational path from in_valid to in_ready. in_ready depends on out_ready combinationally, by design.
- Zero-keep slices inside non-last words are emitted unchanged.

Decomposition:
- Package axis_width_pkg holds:
  - a localparam function clog2_safe;
  - a slice-select function slice_pos(p, RATIO, MSB_FIRST).
- One sub-module, axis_keep_beat_count:
  - combinational;
  - input is keep, plus in_last and the parameters;
  - output is nbeats.
  - It is instantiated once, on the input side.

Test Plan:
- RATIO=2, MSB_FIRST=1, out_ready=1, word A=(hi=0xAA.., lo=0xBB..), full keep, in_last=0, then word B same but in_last=1 -> beats 0xAA..,0xBB..,0xAA..,0xBB.. on 4 consecutive cycles; out_last=1 only on the 4th; in_ready low on the cycle A's first beat is emitted.
- RATIO=2 last word, keep upper=all-ones, lower=0, DROP_EMPTY=1 -> single beat (upper slice) with out_last=1; with DROP_EMPTY=0 -> two beats, the second with keep 0 and out_last=1.
- RATIO=4, MSB_FIRST=0, last word with keep nonzero only in slices 0 and 1 -> 2 beats (slice 0, then slice 1 with out_last=1); next word accepted on the cycle of beat 2.
- out_ready toggled 1,0,0,1,0,1 during a RATIO=2 stream of 3 words -> data, keep and last stable while stalled; exactly 6 beats in order; no duplicates.
- All-zero keep on a last word -> one beat with keep=0 and out_last=1.
- rst_n pulsed low for 1 cycle after the first beat of a 2-beat word -> out_valid=0 the following cycle; the second beat is never emitted; the next word emits normally.
